// File: rtl/amba_axi4_stream_mon_pkg.sv
// Shared definitions for the multi-channel AXI4-Stream protocol monitor:
// error flag bit positions, channel FSM states and default parameters.
package amba_axi4_stream_mon_pkg;

  // Bit positions inside one channel's 5-bit sticky error field
  localparam int ERR_STABLE = 0;
  localparam int ERR_STALL  = 1;
  localparam int ERR_STRB   = 2;
  localparam int ERR_ROUTE  = 3;
  localparam int ERR_LEN    = 4;
  localparam int ERR_W      = 5;

  // Packet framing state of a channel
  typedef enum logic {
    MON_IDLE   = 1'b0,
    MON_ACTIVE = 1'b1
  } mon_state_e;

  // Default parameter values
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DATA_BYTES = 4;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_DEST_WIDTH = 4;
  localparam int DEF_MAXWAITS   = 16;
  localparam int DEF_MIN_PACKET = 1;
  localparam int DEF_MAX_PACKET = 256;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/amba_axi4_stream_mon_if.sv
// Flattened multi-channel AXI4-Stream bundle. Channel c occupies slice c
// of every bus. The monitor modport observes everything and drives nothing.
interface amba_axi4_stream_mon_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_BYTES = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4
);

  logic [NUM_CH-1:0]              TVALID;
  logic [NUM_CH-1:0]              TREADY;
  logic [NUM_CH-1:0]              TLAST;
  logic [NUM_CH*DATA_BYTES*8-1:0] TDATA;
  logic [NUM_CH*DATA_BYTES-1:0]   TSTRB;
  logic [NUM_CH*DATA_BYTES-1:0]   TKEEP;
  logic [NUM_CH*ID_WIDTH-1:0]     TID;
  logic [NUM_CH*DEST_WIDTH-1:0]   TDEST;

  modport master (
    output TVALID, TLAST, TDATA, TSTRB, TKEEP, TID, TDEST,
    input  TREADY
  );

  modport slave (
    input  TVALID, TLAST, TDATA, TSTRB, TKEEP, TID, TDEST,
    output TREADY
  );

  modport monitor (
    input TVALID, TREADY, TLAST, TDATA, TSTRB, TKEEP, TID, TDEST
  );

endinterface

// File: rtl/amba_axi4_stream_mon_ch.sv
// One monitored AXI4-Stream channel: packet framing FSM, wait and beat
// counters, payload snapshot for stability checking, sticky error flags
// and a completed-packet counter.
module amba_axi4_stream_mon_ch
  import amba_axi4_stream_mon_pkg::*;
#(
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int DEST_WIDTH = DEF_DEST_WIDTH,
  parameter int MAXWAITS   = DEF_MAXWAITS,
  parameter int MIN_PACKET = DEF_MIN_PACKET,
  parameter int MAX_PACKET = DEF_MAX_PACKET,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tvalid,
  input  logic                    tready,
  input  logic                    tlast,
  input  logic [DATA_BYTES*8-1:0] tdata,
  input  logic [DATA_BYTES-1:0]   tstrb,
  input  logic [DATA_BYTES-1:0]   tkeep,
  input  logic [ID_WIDTH-1:0]     tid,
  input  logic [DEST_WIDTH-1:0]   tdest,
  input  logic                    err_clr,
  output logic [ERR_W-1:0]        err,
  output logic [CNT_WIDTH-1:0]    pkt_cnt
);

  localparam int PAY_W   = DATA_BYTES*8 + 2*DATA_BYTES + 1 + ID_WIDTH + DEST_WIDTH;
  // Wait counter must be able to exceed MAXWAITS+1 before saturating
  localparam int WAIT_W  = $clog2(MAXWAITS + 2) + 1;
  // Beat counter sized for whichever packet bound is larger
  localparam int LEN_REF = (MAX_PACKET > MIN_PACKET) ? MAX_PACKET : MIN_PACKET;
  localparam int LEN_W   = $clog2(LEN_REF + 1) + 1;

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAXWAITS);
  localparam logic [LEN_W-1:0]  MAX_LIM  = LEN_W'(MAX_PACKET);
  localparam logic [LEN_W-1:0]  MIN_LIM  = LEN_W'(MIN_PACKET);

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  logic              beat;
  logic              stall;
  logic [PAY_W-1:0]  pay;
  logic [LEN_W-1:0]  len_now;
  logic [ERR_W-1:0]  err_set;
  mon_state_e        state_nx;

  mon_state_e        state_p1;
  logic              armed_p1;
  logic              hold_vld_p1;
  logic [PAY_W-1:0]  pay_p1;
  logic [WAIT_W-1:0] wait_cnt_p1;
  logic [LEN_W-1:0]  len_cnt_p1;
  logic [ID_WIDTH-1:0]   id_p1;
  logic [DEST_WIDTH-1:0] dest_p1;

  assign beat    = tvalid & tready;
  assign stall   = tvalid & ~tready;
  assign pay     = {tdata, tstrb, tkeep, tlast, tid, tdest};
  // Beat count including the beat currently on the bus
  assign len_now = sat_inc_len(len_cnt_p1);

  // Framing state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= MON_IDLE;
    end else begin
      state_p1 <= state_nx;
    end
  end

  // Next framing state and this cycle's protocol violations
  always_comb begin
    state_nx = state_p1;
    err_set  = '0;
    if (beat) begin
      if (state_p1 == MON_IDLE) begin
        if (!tlast) state_nx = MON_ACTIVE;
      end else if (tlast) begin
        state_nx = MON_IDLE;
      end
    end
    // armed_p1 is low during reset and the first cycle after it
    if (armed_p1) begin
      if (hold_vld_p1 && (!tvalid || (pay != pay_p1)))
        err_set[ERR_STABLE] = 1'b1;
      // MAXWAITS+1 consecutive waits are tolerated, the next one flags
      if ((MAXWAITS != 0) && stall && (wait_cnt_p1 > WAIT_LIM))
        err_set[ERR_STALL] = 1'b1;
      if (beat && (|(tstrb & ~tkeep)))
        err_set[ERR_STRB] = 1'b1;
      if (beat && (state_p1 == MON_ACTIVE) && ((tid != id_p1) || (tdest != dest_p1)))
        err_set[ERR_ROUTE] = 1'b1;
      if (beat && (MAX_PACKET != 0) && (len_now > MAX_LIM))
        err_set[ERR_LEN] = 1'b1;
      if (beat && tlast && (MIN_PACKET != 0) && (len_now < MIN_LIM))
        err_set[ERR_LEN] = 1'b1;
    end
  end

  // Stall tracking: payload snapshot, hold flag and consecutive-wait count
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_p1 <= 1'b0;
      wait_cnt_p1 <= '0;
      pay_p1      <= '0;
    end else begin
      hold_vld_p1 <= stall;
      if (stall) begin
        pay_p1      <= pay;
        wait_cnt_p1 <= sat_inc_wait(wait_cnt_p1);
      end else begin
        wait_cnt_p1 <= '0;
      end
    end
  end

  // Packet tracking: beat count, route reference, completed packets
  always_ff @(posedge clk) begin
    if (rst) begin
      len_cnt_p1 <= '0;
      id_p1      <= '0;
      dest_p1    <= '0;
      pkt_cnt    <= '0;
    end else if (beat) begin
      len_cnt_p1 <= tlast ? '0 : len_now;
      if (state_p1 == MON_IDLE) begin
        id_p1   <= tid;
        dest_p1 <= tdest;
      end
      if (tlast) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
    end
  end

  // Sticky flags: a new violation outranks a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_p1 <= 1'b0;
      err      <= '0;
    end else begin
      armed_p1 <= 1'b1;
      err      <= (err & ~{ERR_W{err_clr}}) | err_set;
    end
  end

endmodule

// File: rtl/amba_axi4_stream_mon.sv
// Passive multi-channel AXI4-Stream protocol monitor. One checker per
// channel; their sticky flags are concatenated and OR-reduced into a
// registered summary flag.
module amba_axi4_stream_mon
  import amba_axi4_stream_mon_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int DEST_WIDTH = DEF_DEST_WIDTH,
  parameter int MAXWAITS   = DEF_MAXWAITS,
  parameter int MIN_PACKET = DEF_MIN_PACKET,
  parameter int MAX_PACKET = DEF_MAX_PACKET,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  amba_axi4_stream_mon_if.monitor     axis,
  input  logic [NUM_CH-1:0]           ERR_CLR,
  output logic [NUM_CH*ERR_W-1:0]     ERR,
  output logic                        ERR_ANY,
  output logic [NUM_CH*CNT_WIDTH-1:0] PKT_CNT
);

  localparam int DW = DATA_BYTES * 8;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    amba_axi4_stream_mon_ch #(
      .DATA_BYTES (DATA_BYTES),
      .ID_WIDTH   (ID_WIDTH),
      .DEST_WIDTH (DEST_WIDTH),
      .MAXWAITS   (MAXWAITS),
      .MIN_PACKET (MIN_PACKET),
      .MAX_PACKET (MAX_PACKET),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_ch (
      .clk     (ACLK),
      .rst     (ARESET),
      .tvalid  (axis.TVALID[c]),
      .tready  (axis.TREADY[c]),
      .tlast   (axis.TLAST[c]),
      .tdata   (axis.TDATA[c*DW +: DW]),
      .tstrb   (axis.TSTRB[c*DATA_BYTES +: DATA_BYTES]),
      .tkeep   (axis.TKEEP[c*DATA_BYTES +: DATA_BYTES]),
      .tid     (axis.TID[c*ID_WIDTH +: ID_WIDTH]),
      .tdest   (axis.TDEST[c*DEST_WIDTH +: DEST_WIDTH]),
      .err_clr (ERR_CLR[c]),
      .err     (ERR[c*ERR_W +: ERR_W]),
      .pkt_cnt (PKT_CNT[c*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  // Summary flag, one register behind the per-channel flags
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ERR_ANY <= 1'b0;
    end else begin
      ERR_ANY <= |ERR;
    end
  end

endmodule

// File: tb/tb_amba_axi4_stream_mon.sv
// Directed bench for the multi-channel AXI4-Stream monitor.
// Configuration: 4 channels, MAXWAITS=16, MIN_PACKET=2, MAX_PACKET=4,
// 3-bit packet counters so that wrap-around is reachable.
module tb_amba_axi4_stream_mon;
  import amba_axi4_stream_mon_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DB     = 4;
  localparam int IDW    = 4;
  localparam int DSW    = 4;
  localparam int MAXW   = 16;
  localparam int MINP   = 2;
  localparam int MAXP   = 4;
  localparam int CW     = 3;

  logic                     ACLK = 1'b0;
  logic                     ARESET;
  logic [NUM_CH-1:0]        ERR_CLR;
  logic [NUM_CH*ERR_W-1:0]  ERR;
  logic                     ERR_ANY;
  logic [NUM_CH*CW-1:0]     PKT_CNT;

  int tests = 0;
  int fails = 0;

  amba_axi4_stream_mon_if #(
    .NUM_CH(NUM_CH), .DATA_BYTES(DB), .ID_WIDTH(IDW), .DEST_WIDTH(DSW)
  ) mi ();

  amba_axi4_stream_mon #(
    .NUM_CH(NUM_CH), .DATA_BYTES(DB), .ID_WIDTH(IDW), .DEST_WIDTH(DSW),
    .MAXWAITS(MAXW), .MIN_PACKET(MINP), .MAX_PACKET(MAXP), .CNT_WIDTH(CW)
  ) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .axis    (mi),
    .ERR_CLR (ERR_CLR),
    .ERR     (ERR),
    .ERR_ANY (ERR_ANY),
    .PKT_CNT (PKT_CNT)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_ch(input int c, input logic v, input logic r, input logic l,
                        input logic [31:0] d, input logic [3:0] s, input logic [3:0] k,
                        input logic [3:0] id, input logic [3:0] dst);
    mi.TVALID[c]          = v;
    mi.TREADY[c]          = r;
    mi.TLAST[c]           = l;
    mi.TDATA[c*32 +: 32]  = d;
    mi.TSTRB[c*4 +: 4]    = s;
    mi.TKEEP[c*4 +: 4]    = k;
    mi.TID[c*4 +: 4]      = id;
    mi.TDEST[c*4 +: 4]    = dst;
  endtask

  task automatic idle_ch(input int c);
    set_ch(c, 1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 4'hF, 4'h0, 4'h0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pcnt(input int c);
    return 32'(PKT_CNT[c*CW +: CW]);
  endfunction

  initial begin
    ARESET  = 1'b1;
    ERR_CLR = '0;
    for (int c = 0; c < NUM_CH; c++) idle_ch(c);
    tick();
    tick();
    check("rst_err",     32'(ERR),     32'h0);
    check("rst_err_any", 32'(ERR_ANY), 32'h0);
    check("rst_pkt_cnt", 32'(PKT_CNT), 32'h0);
    ARESET = 1'b0;
    tick();

    // Ch0: clean 4-beat packet, TID=3, exactly MAX_PACKET beats
    set_ch(0, 1, 1, 0, 32'h00000011, 4'hF, 4'hF, 4'd3, 4'd1); tick();
    set_ch(0, 1, 1, 0, 32'h00000022, 4'hF, 4'hF, 4'd3, 4'd1); tick();
    set_ch(0, 1, 1, 0, 32'h00000033, 4'hF, 4'hF, 4'd3, 4'd1); tick();
    check("pkt0_before_last", pcnt(0), 32'd0);
    set_ch(0, 1, 1, 1, 32'h00000044, 4'hF, 4'hF, 4'd3, 4'd1); tick();
    check("pkt0_after_last", pcnt(0), 32'd1);
    check("pkt0_err", 32'(ERR), 32'h0);
    idle_ch(0); tick();
    check("pkt0_err_any", 32'(ERR_ANY), 32'h0);

    // Ch1: payload changes while stalled
    set_ch(1, 1, 0, 0, 32'hA5A5A5A5, 4'hF, 4'hF, 4'd0, 4'd0); tick();
    check("stable_first_stall", 32'(ERR), 32'h0);
    set_ch(1, 1, 0, 0, 32'h5A5A5A5A, 4'hF, 4'hF, 4'd0, 4'd0); tick();
    check("stable_set", 32'(ERR), 32'h00020);
    check("stable_any_lag", 32'(ERR_ANY), 32'h0);
    tick();
    check("stable_any", 32'(ERR_ANY), 32'h1);
    check("stable_only_ch1", 32'(ERR), 32'h00020);
    set_ch(1, 1, 1, 0, 32'h5A5A5A5A, 4'hF, 4'hF, 4'd0, 4'd0); tick();
    set_ch(1, 1, 1, 1, 32'h5A5A5A5A, 4'hF, 4'hF, 4'd0, 4'd0); tick();
    check("pkt1_min_len", pcnt(1), 32'd1);
    idle_ch(1);
    ERR_CLR = 4'b0010; tick();
    check("stable_clr", 32'(ERR), 32'h0);
    ERR_CLR = 4'b0000; tick();
    check("stable_any_clr", 32'(ERR_ANY), 32'h0);

    // Ch2: 17 waits tolerated
    set_ch(2, 1, 0, 0, 32'hC0FFEE00, 4'hF, 4'hF, 4'd2, 4'd2);
    for (int i = 0; i < 17; i++) tick();
    check("stall17_ok", 32'(ERR), 32'h0);
    set_ch(2, 1, 1, 0, 32'hC0FFEE00, 4'hF, 4'hF, 4'd2, 4'd2); tick();
    set_ch(2, 1, 1, 1, 32'hC0FFEE00, 4'hF, 4'hF, 4'd2, 4'd2); tick();
    check("stall17_after", 32'(ERR), 32'h0);
    check("pkt2_first", pcnt(2), 32'd1);
    idle_ch(2); tick();

    // Ch2: 18th wait flags, clear racing a persisting stall keeps the flag
    set_ch(2, 1, 0, 0, 32'hC0FFEE01, 4'hF, 4'hF, 4'd2, 4'd2);
    for (int i = 0; i < 17; i++) tick();
    check("stall18_pre", 32'(ERR), 32'h0);
    tick();
    check("stall18_set", 32'(ERR), 32'h00800);
    ERR_CLR = 4'b0100; tick();
    check("clr_vs_new", 32'(ERR), 32'h00800);
    set_ch(2, 1, 1, 0, 32'hC0FFEE01, 4'hF, 4'hF, 4'd2, 4'd2); tick();
    check("stall_clr", 32'(ERR), 32'h0);
    ERR_CLR = 4'b0000;
    set_ch(2, 1, 1, 1, 32'hC0FFEE01, 4'hF, 4'hF, 4'd2, 4'd2); tick();
    idle_ch(2); tick();
    check("stall_any_clr", 32'(ERR_ANY), 32'h0);
    check("pkt2_second", pcnt(2), 32'd2);

    // Ch3: TSTRB set on a null byte, then TDEST changes mid-packet
    set_ch(3, 1, 1, 0, 32'h12345678, 4'b1111, 4'b0111, 4'd1, 4'd2); tick();
    check("strb_set", 32'(ERR), 32'h20000);
    set_ch(3, 1, 1, 1, 32'h9ABCDEF0, 4'b1111, 4'b1111, 4'd1, 4'd5); tick();
    check("route_set", 32'(ERR), 32'h60000);
    check("route_any", 32'(ERR_ANY), 32'h1);
    check("pkt3_first", pcnt(3), 32'd1);
    idle_ch(3);
    ERR_CLR = 4'b1000; tick();
    ERR_CLR = 4'b0000;
    check("ch3_clr", 32'(ERR), 32'h0);

    // Ch0: 5-beat packet exceeds MAX_PACKET on beat 5
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1, 1, 0, 32'h100 + 32'(i), 4'hF, 4'hF, 4'd3, 4'd1); tick();
    end
    check("len_beat4_ok", 32'(ERR), 32'h0);
    set_ch(0, 1, 1, 1, 32'h00000104, 4'hF, 4'hF, 4'd3, 4'd1); tick();
    check("len_max", 32'(ERR), 32'h00010);
    check("pkt0_long", pcnt(0), 32'd2);
    idle_ch(0);
    ERR_CLR = 4'b0001; tick();
    check("len_max_clr", 32'(ERR), 32'h0);
    // Ch0: single-beat packet below MIN_PACKET
    ERR_CLR = 4'b0000;
    set_ch(0, 1, 1, 1, 32'h00000200, 4'hF, 4'hF, 4'd3, 4'd1); tick();
    check("len_min", 32'(ERR), 32'h00010);
    check("pkt0_short", pcnt(0), 32'd3);
    idle_ch(0);
    ERR_CLR = 4'b0001; tick();
    ERR_CLR = 4'b0000;
    check("len_min_clr", 32'(ERR), 32'h0);

    // Ch1: reset after beat 2 of an open packet
    set_ch(1, 1, 1, 0, 32'h00000301, 4'hF, 4'hF, 4'd4, 4'd4); tick();
    set_ch(1, 1, 1, 0, 32'h00000302, 4'hF, 4'hF, 4'd4, 4'd4); tick();
    idle_ch(1);
    ARESET = 1'b1; tick();
    check("midrst_pkt_cnt", 32'(PKT_CNT), 32'h0);
    check("midrst_err", 32'(ERR), 32'h0);
    ARESET = 1'b0;
    // First cycle after reset: a bad single-beat packet on ch0 is not flagged
    set_ch(0, 1, 1, 1, 32'h00000400, 4'hF, 4'h0, 4'd0, 4'd0); tick();
    idle_ch(0);
    check("post_rst_suspend", 32'(ERR), 32'h0);
    check("post_rst_pkt0", pcnt(0), 32'd1);
    // Fresh 3-beat packet with new TID/TDEST
    set_ch(1, 1, 1, 0, 32'h00000501, 4'hF, 4'hF, 4'd7, 4'd9); tick();
    set_ch(1, 1, 1, 0, 32'h00000502, 4'hF, 4'hF, 4'd7, 4'd9); tick();
    set_ch(1, 1, 1, 1, 32'h00000503, 4'hF, 4'hF, 4'd7, 4'd9); tick();
    idle_ch(1);
    check("fresh_pkt_err", 32'(ERR), 32'h0);
    check("fresh_pkt_cnt", pcnt(1), 32'd1);

    // Ch3: packet counter wraps modulo 2^CW
    for (int p = 0; p < 7; p++) begin
      set_ch(3, 1, 1, 0, 32'(p), 4'hF, 4'hF, 4'd6, 4'd6); tick();
      set_ch(3, 1, 1, 1, 32'(p), 4'hF, 4'hF, 4'd6, 4'd6); tick();
    end
    check("wrap_pre", pcnt(3), 32'd7);
    set_ch(3, 1, 1, 0, 32'h77, 4'hF, 4'hF, 4'd6, 4'd6); tick();
    set_ch(3, 1, 1, 1, 32'h77, 4'hF, 4'hF, 4'd6, 4'd6); tick();
    idle_ch(3); tick();
    check("wrap_zero", pcnt(3), 32'd0);
    check("wrap_err", 32'(ERR), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
